// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the RV32I pipeline (master) and hazard_ctrl (slave).
interface hazard_ctrl_if #(
   parameter int unsigned CNT_W = 16
);
   logic             id_valid;
   logic [4:0]       id_rs1;
   logic [4:0]       id_rs2;
   logic             id_rs1_used;
   logic             id_rs2_used;
   logic [4:0]       id_rd;
   logic             id_rd_wren;
   logic             id_is_load;
   logic             ex_br_taken;
   logic             stall_pc;
   logic             flush_ifid;
   logic             bubble_idex;
   logic             freeze;
   logic [1:0]       forward_a_sel;
   logic [1:0]       forward_b_sel;
   logic [CNT_W-1:0] stall_count;

   modport master (
      output id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_rd_wren, id_is_load, ex_br_taken,
      input  stall_pc, flush_ifid, bubble_idex, freeze,
             forward_a_sel, forward_b_sel, stall_count
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_rs1_used, id_rs2_used,
             id_rd, id_rd_wren, id_is_load, ex_br_taken,
      output stall_pc, flush_ifid, bubble_idex, freeze,
             forward_a_sel, forward_b_sel, stall_count
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage RV32I pipeline: tracks in-flight destinations, drives
// registered EX forward selects, load-use/RAW stalls, branch flushes and LSU freezes.
module hazard_ctrl #(
   parameter bit          FWD_EN    = 1'b1,
   parameter bit          RF_BYPASS = 1'b1,
   parameter int unsigned LOAD_LAT  = 1,
   parameter int unsigned CNT_W     = 16
) (
   input  logic         clk,
   input  logic         rst,
   hazard_ctrl_if.slave hz_if
);

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       wren;
      logic       load;
   } slot_t;

   localparam bit         FRZ_USED = (LOAD_LAT > 1);
   localparam logic [2:0] FRZ_LOAD = 3'(LOAD_LAT - 1);

   slot_t            r_ex, r_mem, r_wb;
   logic [2:0]       r_frz_cnt;
   logic [1:0]       r_fwd_a, r_fwd_b;
   logic [CNT_W-1:0] r_stall_cnt;

   slot_t      w_ex_nx;
   logic       w_freeze, w_src_a, w_src_b;
   logic       w_mex_a, w_mmem_a, w_mwb_a, w_mex_b, w_mmem_b, w_mwb_b;
   logic       w_ex_any, w_mem_any, w_wb_any, w_wb_only, w_load_use;
   logic       w_raw_hazard, w_stall_pc, w_flush_ifid, w_bubble_idex;
   logic [1:0] w_fwd_a_nx, w_fwd_b_nx;
   logic       w_unused;

   function automatic logic slot_match(input slot_t s, input logic [4:0] src, input logic used);
      return used & s.valid & s.wren & (s.rd == src) & (s.rd != 5'd0);
   endfunction

   function automatic logic [1:0] fwd_sel(input logic m_ex, input logic m_mem);
      logic [1:0] sel;
      if (m_ex) begin
         sel = 2'b01;
      end else if (m_mem) begin
         sel = 2'b10;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   assign w_freeze = (r_frz_cnt != 3'd0);
   assign w_src_a  = hz_if.id_valid & hz_if.id_rs1_used;
   assign w_src_b  = hz_if.id_valid & hz_if.id_rs2_used;

   assign w_mex_a  = slot_match(r_ex,  hz_if.id_rs1, w_src_a);
   assign w_mmem_a = slot_match(r_mem, hz_if.id_rs1, w_src_a);
   assign w_mwb_a  = slot_match(r_wb,  hz_if.id_rs1, w_src_a);
   assign w_mex_b  = slot_match(r_ex,  hz_if.id_rs2, w_src_b);
   assign w_mmem_b = slot_match(r_mem, hz_if.id_rs2, w_src_b);
   assign w_mwb_b  = slot_match(r_wb,  hz_if.id_rs2, w_src_b);

   assign w_ex_any   = w_mex_a | w_mex_b;
   assign w_mem_any  = w_mmem_a | w_mmem_b;
   assign w_wb_any   = w_mwb_a | w_mwb_b;
   // A WB match only matters when no newer producer already covers that source.
   assign w_wb_only  = (w_mwb_a & ~w_mex_a & ~w_mmem_a) | (w_mwb_b & ~w_mex_b & ~w_mmem_b);
   assign w_load_use = r_ex.load & w_ex_any;
   assign w_unused   = r_mem.load ^ r_wb.load;

   always_comb begin
      w_raw_hazard = 1'b0;
      if (FWD_EN) begin
         w_raw_hazard = w_load_use | ((RF_BYPASS == 1'b0) & w_wb_only);
      end else begin
         w_raw_hazard = w_ex_any | w_mem_any | ((RF_BYPASS == 1'b0) & w_wb_any);
      end
   end

   // Freeze masks everything; a taken branch beats a stall so the redirect PC loads.
   always_comb begin
      w_stall_pc    = 1'b0;
      w_flush_ifid  = 1'b0;
      w_bubble_idex = 1'b0;
      if (w_freeze) begin
         w_stall_pc    = 1'b0;
      end else if (hz_if.ex_br_taken) begin
         w_flush_ifid  = 1'b1;
         w_bubble_idex = 1'b1;
      end else if (w_raw_hazard) begin
         w_stall_pc    = 1'b1;
         w_bubble_idex = 1'b1;
      end else begin
         w_stall_pc    = 1'b0;
      end
   end

   always_comb begin
      w_ex_nx    = '0;
      w_fwd_a_nx = 2'b00;
      w_fwd_b_nx = 2'b00;
      if (w_bubble_idex) begin
         w_ex_nx = '0;
      end else begin
         w_ex_nx.valid = hz_if.id_valid;
         w_ex_nx.rd    = hz_if.id_rd;
         w_ex_nx.wren  = hz_if.id_rd_wren;
         w_ex_nx.load  = hz_if.id_is_load;
      end
      if (FWD_EN && !w_bubble_idex) begin
         w_fwd_a_nx = fwd_sel(w_mex_a, w_mmem_a);
         w_fwd_b_nx = fwd_sel(w_mex_b, w_mmem_b);
      end else begin
         w_fwd_a_nx = 2'b00;
         w_fwd_b_nx = 2'b00;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ex    <= '0;
         r_mem   <= '0;
         r_wb    <= '0;
         r_fwd_a <= 2'b00;
         r_fwd_b <= 2'b00;
      end else if (!w_freeze) begin
         r_wb    <= r_mem;
         r_mem   <= r_ex;
         r_ex    <= w_ex_nx;
         r_fwd_a <= w_fwd_a_nx;
         r_fwd_b <= w_fwd_b_nx;
      end
   end

   // The counter is loaded on the edge that moves a load from EX into MEM.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_frz_cnt <= 3'd0;
      end else if (w_freeze) begin
         r_frz_cnt <= r_frz_cnt - 3'd1;
      end else if (FRZ_USED && r_ex.valid && r_ex.load) begin
         r_frz_cnt <= FRZ_LOAD;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= {CNT_W{1'b0}};
      end else if ((w_stall_pc || w_freeze) && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign hz_if.stall_pc      = w_stall_pc;
   assign hz_if.flush_ifid    = w_flush_ifid;
   assign hz_if.bubble_idex   = w_bubble_idex;
   assign hz_if.freeze        = w_freeze;
   assign hz_if.forward_a_sel = r_fwd_a;
   assign hz_if.forward_b_sel = r_fwd_b;
   assign hz_if.stall_count   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table on the default configuration plus
// hand sequences for freeze, stall-only, no-bypass, saturation and async reset.
module tb_hazard_ctrl;

   typedef struct packed {
      logic       valid;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       rs1_used;
      logic       rs2_used;
      logic [4:0] rd;
      logic       wren;
      logic       load;
   } ins_t;

   typedef struct packed {
      ins_t        id;
      logic        br;
      logic        stall;
      logic        flush;
      logic        bub;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic [15:0] cnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   hazard_ctrl_if #(.CNT_W(16)) if_m  ();
   hazard_ctrl_if #(.CNT_W(16)) if_l3 ();
   hazard_ctrl_if #(.CNT_W(16)) if_so ();
   hazard_ctrl_if #(.CNT_W(2))  if_sn ();

   hazard_ctrl #(.FWD_EN(1'b1), .RF_BYPASS(1'b1), .LOAD_LAT(1), .CNT_W(16))
      u_m  (.clk(clk), .rst(rst), .hz_if(if_m));
   hazard_ctrl #(.FWD_EN(1'b1), .RF_BYPASS(1'b0), .LOAD_LAT(3), .CNT_W(16))
      u_l3 (.clk(clk), .rst(rst), .hz_if(if_l3));
   hazard_ctrl #(.FWD_EN(1'b0), .RF_BYPASS(1'b1), .LOAD_LAT(1), .CNT_W(16))
      u_so (.clk(clk), .rst(rst), .hz_if(if_so));
   hazard_ctrl #(.FWD_EN(1'b0), .RF_BYPASS(1'b0), .LOAD_LAT(1), .CNT_W(2))
      u_sn (.clk(clk), .rst(rst), .hz_if(if_sn));

   function automatic ins_t mki(input logic v, input logic [4:0] s1, input logic [4:0] s2,
                                input logic u1, input logic u2, input logic [4:0] d,
                                input logic w, input logic ld);
      ins_t x;
      x.valid = v; x.rs1 = s1; x.rs2 = s2; x.rs1_used = u1; x.rs2_used = u2;
      x.rd = d; x.wren = w; x.load = ld;
      return x;
   endfunction

   function automatic vec_t mkv(input ins_t x, input logic br, input logic st, input logic fl,
                                input logic bu, input logic [1:0] fa, input logic [1:0] fb,
                                input logic [15:0] cnt);
      vec_t v;
      v.id = x; v.br = br; v.stall = st; v.flush = fl; v.bub = bu;
      v.fa = fa; v.fb = fb; v.cnt = cnt;
      return v;
   endfunction

   task automatic drv(input ins_t x, input logic br);
      if_m.id_valid = x.valid; if_m.id_rs1 = x.rs1; if_m.id_rs2 = x.rs2; if_m.id_rs1_used = x.rs1_used; if_m.id_rs2_used = x.rs2_used; if_m.id_rd = x.rd; if_m.id_rd_wren = x.wren; if_m.id_is_load = x.load; if_m.ex_br_taken = br;
      if_l3.id_valid = x.valid; if_l3.id_rs1 = x.rs1; if_l3.id_rs2 = x.rs2; if_l3.id_rs1_used = x.rs1_used; if_l3.id_rs2_used = x.rs2_used; if_l3.id_rd = x.rd; if_l3.id_rd_wren = x.wren; if_l3.id_is_load = x.load; if_l3.ex_br_taken = br;
      if_so.id_valid = x.valid; if_so.id_rs1 = x.rs1; if_so.id_rs2 = x.rs2; if_so.id_rs1_used = x.rs1_used; if_so.id_rs2_used = x.rs2_used; if_so.id_rd = x.rd; if_so.id_rd_wren = x.wren; if_so.id_is_load = x.load; if_so.ex_br_taken = br;
      if_sn.id_valid = x.valid; if_sn.id_rs1 = x.rs1; if_sn.id_rs2 = x.rs2; if_sn.id_rs1_used = x.rs1_used; if_sn.id_rs2_used = x.rs2_used; if_sn.id_rd = x.rd; if_sn.id_rd_wren = x.wren; if_sn.id_is_load = x.load; if_sn.ex_br_taken = br;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0b expected %0b", name, act, exp);
      end
   endtask

   task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic cyc(input ins_t x, input logic br);
      drv(x, br);
      @(negedge clk);
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   ins_t I_NOP, I_ADD5, I_SUB6, I_LW5, I_ADD655, I_ADD0, I_R0, I_BNU, I_BR2, I_INV655;
   ins_t I_LW7, I_X, I_LW8, I_Z, I_SUBX6, I_R6, I_ADD658;
   vec_t vt [28];

   task automatic do_reset();
      rst = 1'b0;
      drv(I_NOP, 1'b0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      I_NOP    = mki(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0);
      I_ADD5   = mki(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5,  1'b1, 1'b0);
      I_SUB6   = mki(1'b1, 5'd5, 5'd7, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0);
      I_LW5    = mki(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b1);
      I_ADD655 = mki(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0);
      I_ADD0   = mki(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0,  1'b1, 1'b0);
      I_R0     = mki(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd8,  1'b1, 1'b0);
      I_BNU    = mki(1'b1, 5'd3, 5'd5, 1'b1, 1'b0, 5'd9,  1'b1, 1'b0);
      I_BR2    = mki(1'b1, 5'd3, 5'd5, 1'b1, 1'b1, 5'd9,  1'b1, 1'b0);
      I_INV655 = mki(1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0);
      I_LW7    = mki(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd7,  1'b1, 1'b1);
      I_X      = mki(1'b1, 5'd5, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0);
      I_LW8    = mki(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8,  1'b1, 1'b1);
      I_Z      = mki(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd11, 1'b1, 1'b0);
      I_SUBX6  = mki(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0);
      I_R6     = mki(1'b1, 5'd6, 5'd0, 1'b1, 1'b0, 5'd12, 1'b1, 1'b0);
      I_ADD658 = mki(1'b1, 5'd5, 5'd8, 1'b1, 1'b1, 5'd6,  1'b1, 1'b0);

      // Default DUT: one cycle per row; fa/fb are the selects currently presented to EX.
      vt[0]  = mkv(I_ADD5,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
      vt[1]  = mkv(I_SUB6,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
      vt[2]  = mkv(I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 16'd0);
      vt[3]  = mkv(I_ADD5,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
      vt[4]  = mkv(I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
      vt[5]  = mkv(I_SUB6,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
      vt[6]  = mkv(I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 16'd0);
      vt[7]  = mkv(I_ADD0,   1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
      vt[8]  = mkv(I_R0,     1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
      vt[9]  = mkv(I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
      vt[10] = mkv(I_LW5,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd0);
      vt[11] = mkv(I_ADD655, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 16'd0);
      vt[12] = mkv(I_ADD655, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1);
      vt[13] = mkv(I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 16'd1);
      vt[14] = mkv(I_LW5,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1);
      vt[15] = mkv(I_ADD655, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 16'd1);
      vt[16] = mkv(I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1);
      vt[17] = mkv(I_ADD5,   1'b1, 1'b0, 1'b1, 1'b1, 2'b00, 2'b00, 16'd1);
      vt[18] = mkv(I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1);
      vt[19] = mkv(I_LW5,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1);
      vt[20] = mkv(I_BNU,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1);
      vt[21] = mkv(I_LW5,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd1);
      vt[22] = mkv(I_BR2,    1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 16'd1);
      vt[23] = mkv(I_BR2,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
      vt[24] = mkv(I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 16'd2);
      vt[25] = mkv(I_LW5,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
      vt[26] = mkv(I_INV655, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);
      vt[27] = mkv(I_NOP,    1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 16'd2);

      rst = 1'b1;
      drv(I_NOP, 1'b0);
      #1 rst = 1'b0;
      #1;
      chk1("rst_stall", if_m.stall_pc, 1'b0);
      chk1("rst_freeze", if_l3.freeze, 1'b0);
      chk2("rst_fa", if_m.forward_a_sel, 2'b00);
      chk2("rst_fb", if_m.forward_b_sel, 2'b00);
      chk16("rst_cnt", if_m.stall_count, 16'd0);
      @(posedge clk);
      #1 rst = 1'b1;

      for (int i = 0; i < 28; i++) begin
         cyc(vt[i].id, vt[i].br);
         chk1($sformatf("v%0d_stall", i), if_m.stall_pc, vt[i].stall);
         chk1($sformatf("v%0d_flush", i), if_m.flush_ifid, vt[i].flush);
         chk1($sformatf("v%0d_bubble", i), if_m.bubble_idex, vt[i].bub);
         chk1($sformatf("v%0d_freeze", i), if_m.freeze, 1'b0);
         chk2($sformatf("v%0d_fa", i), if_m.forward_a_sel, vt[i].fa);
         chk2($sformatf("v%0d_fb", i), if_m.forward_b_sel, vt[i].fb);
         chk16($sformatf("v%0d_cnt", i), if_m.stall_count, vt[i].cnt);
         adv();
      end

      // LOAD_LAT=3: load-use stall, then two freeze cycles with a branch ignored.
      do_reset();
      cyc(I_LW5, 1'b0);    chk1("l3a_stall", if_l3.stall_pc, 1'b0); adv();
      cyc(I_ADD655, 1'b0); chk1("l3b_stall", if_l3.stall_pc, 1'b1); chk1("l3b_bub", if_l3.bubble_idex, 1'b1);
                           chk1("l3b_freeze", if_l3.freeze, 1'b0); adv();
      cyc(I_ADD655, 1'b1); chk1("l3c_freeze", if_l3.freeze, 1'b1); chk1("l3c_stall", if_l3.stall_pc, 1'b0);
                           chk1("l3c_flush", if_l3.flush_ifid, 1'b0); chk1("l3c_bub", if_l3.bubble_idex, 1'b0); adv();
      cyc(I_ADD655, 1'b0); chk1("l3d_freeze", if_l3.freeze, 1'b1); chk1("l3d_stall", if_l3.stall_pc, 1'b0); adv();
      cyc(I_ADD655, 1'b0); chk1("l3e_freeze", if_l3.freeze, 1'b0); chk1("l3e_stall", if_l3.stall_pc, 1'b0);
                           chk2("l3e_fa", if_l3.forward_a_sel, 2'b00); adv();
      cyc(I_NOP, 1'b0);    chk2("l3f_fa", if_l3.forward_a_sel, 2'b10); chk2("l3f_fb", if_l3.forward_b_sel, 2'b10);
                           chk16("l3f_cnt", if_l3.stall_count, 16'd3); adv();
      // Nonzero selects captured just before the freeze must hold through it.
      cyc(I_ADD5, 1'b0);   chk1("l3g_freeze", if_l3.freeze, 1'b0); adv();
      cyc(I_LW7, 1'b0);    chk1("l3h_stall", if_l3.stall_pc, 1'b0); adv();
      cyc(I_X, 1'b0);      chk2("l3i_fa", if_l3.forward_a_sel, 2'b01); chk1("l3i_stall", if_l3.stall_pc, 1'b0); adv();
      cyc(I_NOP, 1'b0);    chk1("l3j_freeze", if_l3.freeze, 1'b1); chk2("l3j_fa", if_l3.forward_a_sel, 2'b10);
                           chk2("l3j_fb", if_l3.forward_b_sel, 2'b00); adv();
      cyc(I_NOP, 1'b0);    chk1("l3k_freeze", if_l3.freeze, 1'b1); chk2("l3k_fa", if_l3.forward_a_sel, 2'b10); adv();
      cyc(I_NOP, 1'b0);    chk1("l3l_freeze", if_l3.freeze, 1'b0); chk2("l3l_fa", if_l3.forward_a_sel, 2'b10);
                           chk16("l3l_cnt", if_l3.stall_count, 16'd5); adv();
      cyc(I_NOP, 1'b0);    chk2("l3m_fa", if_l3.forward_a_sel, 2'b00); adv();
      cyc(I_ADD5, 1'b0);   adv();
      cyc(I_LW8, 1'b0);    adv();
      cyc(I_Z, 1'b0);      chk2("l3n3_fa", if_l3.forward_a_sel, 2'b00); adv();
      cyc(I_NOP, 1'b0);    chk1("l3n4_freeze", if_l3.freeze, 1'b1); chk2("l3n4_fa", if_l3.forward_a_sel, 2'b10);
      #1 rst = 1'b0;
      #1;
      chk1("arst_freeze", if_l3.freeze, 1'b0);
      chk2("arst_fa", if_l3.forward_a_sel, 2'b00);
      chk2("arst_fb", if_l3.forward_b_sel, 2'b00);
      chk16("arst_cnt", if_l3.stall_count, 16'd0);
      @(posedge clk);
      #1 rst = 1'b1;
      cyc(I_ADD658, 1'b0); chk1("post_stall", if_l3.stall_pc, 1'b0); chk1("post_bub", if_l3.bubble_idex, 1'b0);
                           chk1("post_freeze", if_l3.freeze, 1'b0); chk16("post_cnt", if_l3.stall_count, 16'd0); adv();
      cyc(I_NOP, 1'b0);    chk2("post_fa", if_l3.forward_a_sel, 2'b00); chk2("post_fb", if_l3.forward_b_sel, 2'b00);
                           chk1("post_freeze2", if_l3.freeze, 1'b0); adv();

      // add x5 then add x6,x5,x0 held in ID: stall-only (so/sn) and forwarding without bypass (l3).
      do_reset();
      cyc(I_ADD5, 1'b0);  chk1("b1_so", if_so.stall_pc, 1'b0); chk1("b1_sn", if_sn.stall_pc, 1'b0);
                          chk1("b1_nb", if_l3.stall_pc, 1'b0); adv();
      cyc(I_SUBX6, 1'b0); chk1("b2_so", if_so.stall_pc, 1'b1); chk1("b2_so_bub", if_so.bubble_idex, 1'b1);
                          chk1("b2_sn", if_sn.stall_pc, 1'b1); chk1("b2_nb", if_l3.stall_pc, 1'b0); adv();
      cyc(I_SUBX6, 1'b0); chk1("b3_so", if_so.stall_pc, 1'b1); chk1("b3_sn", if_sn.stall_pc, 1'b1);
                          chk1("b3_nb", if_l3.stall_pc, 1'b0); chk2("b3_nb_fa", if_l3.forward_a_sel, 2'b01);
                          chk2("b3_so_fa", if_so.forward_a_sel, 2'b00); adv();
      cyc(I_SUBX6, 1'b0); chk1("b4_so", if_so.stall_pc, 1'b0); chk1("b4_sn", if_sn.stall_pc, 1'b1);
                          chk1("b4_nb", if_l3.stall_pc, 1'b1); chk1("b4_nb_bub", if_l3.bubble_idex, 1'b1);
                          chk2("b4_nb_fa", if_l3.forward_a_sel, 2'b10); adv();
      cyc(I_SUBX6, 1'b0); chk1("b5_so", if_so.stall_pc, 1'b0); chk1("b5_sn", if_sn.stall_pc, 1'b0);
                          chk1("b5_nb", if_l3.stall_pc, 1'b0); chk2("b5_nb_fa", if_l3.forward_a_sel, 2'b00);
                          chk16("b5_so_cnt", if_so.stall_count, 16'd2); chk16("b5_sn_cnt", {14'd0, if_sn.stall_count}, 16'd3);
                          chk16("b5_nb_cnt", if_l3.stall_count, 16'd1); adv();
      cyc(I_R6, 1'b0);    chk1("b6_sn", if_sn.stall_pc, 1'b1); chk2("b6_so_fa", if_so.forward_a_sel, 2'b00);
                          chk16("b6_sn_cnt", {14'd0, if_sn.stall_count}, 16'd3); adv();
      cyc(I_R6, 1'b0);    chk1("b7_sn", if_sn.stall_pc, 1'b1);
                          chk16("b7_sn_sat", {14'd0, if_sn.stall_count}, 16'd3); adv();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
